// File: rtl/calendar_date_counter.sv
// -----------------------------------------------------------------------------
// calendar_date_counter
//
// Calendar stage that follows the time-of-day clock. It advances day, month,
// year (offset from 2000, 0..99) and weekday on each one-cycle new_day pulse.
// A set path loads a date from the board switches after a one-cycle
// validation step.
//
// Optional feature macro: LEAP_YEAR_EN
//   defined   -> February has 29 days when year[1:0] == 0
//   undefined -> February always has 28 days
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   new_day      in   one-cycle day-advance pulse
//   set_req      in   one-cycle request to load set_*
//   set_day      in   [4:0] requested day
//   set_month    in   [3:0] requested month
//   set_year     in   [6:0] requested year offset
//   set_weekday  in   [2:0] requested weekday (0 = Monday)
//   day          out  [4:0] current day, 1..31
//   month        out  [3:0] current month, 1..12
//   year         out  [6:0] current year offset, 0..99
//   weekday      out  [2:0] current weekday, 0..6
//   new_month    out  one-cycle pulse when the month increments
//   new_year     out  one-cycle pulse when the year increments or wraps
//   busy         out  high while a set request is being validated
//   set_err      out  one-cycle pulse when a set request is rejected
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module calendar_date_counter #(
    parameter int INIT_DAY     = 1,
    parameter int INIT_MONTH   = 1,
    parameter int INIT_YEAR    = 0,
    parameter int INIT_WEEKDAY = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_day,
    input  logic       set_req,
    input  logic [4:0] set_day,
    input  logic [3:0] set_month,
    input  logic [6:0] set_year,
    input  logic [2:0] set_weekday,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [2:0] weekday,
    output logic       new_month,
    output logic       new_year,
    output logic       busy,
    output logic       set_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t     state_q, state_d;

    logic [4:0] day_q, day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic [2:0] weekday_q, weekday_d;
    logic       new_month_q, new_month_d;
    logic       new_year_q, new_year_d;
    logic       set_err_q, set_err_d;
    logic       pending_q, pending_d;

    // Shadow copy of the set request, held for the validation cycle.
    logic [4:0] cap_day_q, cap_day_d;
    logic [3:0] cap_month_q, cap_month_d;
    logic [6:0] cap_year_q, cap_year_d;
    logic [2:0] cap_weekday_q, cap_weekday_d;

    logic       cur_leap;
    logic       cap_leap;
    logic [4:0] cur_len;
    logic [4:0] cap_len;
    logic       cap_valid;
    logic       do_adv;

    // Days in a month; out-of-range months return 31 but are always gated
    // by a separate month range check before the length is used.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return leap ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    // Within 2000..2099 every multiple of 4 is a leap year, 2000 included.
    assign cur_leap = (year_q[1:0] == 2'b00);
    assign cap_leap = (cap_year_q[1:0] == 2'b00);
`else
    assign cur_leap = 1'b0;
    assign cap_leap = 1'b0;
`endif

    assign cur_len = month_len(month_q, cur_leap);
    assign cap_len = month_len(cap_month_q, cap_leap);

    assign cap_valid = (cap_month_q >= 4'd1) && (cap_month_q <= 4'd12) &&
                       (cap_day_q   >= 5'd1) && (cap_day_q   <= cap_len) &&
                       (cap_year_q  <= 7'd99) && (cap_weekday_q <= 3'd6);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (set_req) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CHECK);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        day_d         = day_q;
        month_d       = month_q;
        year_d        = year_q;
        weekday_d     = weekday_q;
        new_month_d   = 1'b0;
        new_year_d    = 1'b0;
        set_err_d     = 1'b0;
        pending_d     = pending_q;
        cap_day_d     = cap_day_q;
        cap_month_d   = cap_month_q;
        cap_year_d    = cap_year_q;
        cap_weekday_d = cap_weekday_q;
        do_adv        = 1'b0;

        case (state_q)
            IDLE: begin
                // A set takes priority over a coincident new_day, which is
                // remembered and applied after the set resolves.
                do_adv    = pending_q | (new_day & ~set_req);
                pending_d = set_req & new_day;
                if (set_req) begin
                    cap_day_d     = set_day;
                    cap_month_d   = set_month;
                    cap_year_d    = set_year;
                    cap_weekday_d = set_weekday;
                end
            end
            CHECK: begin
                pending_d = pending_q | new_day;
                if (cap_valid) begin
                    day_d     = cap_day_q;
                    month_d   = cap_month_q;
                    year_d    = cap_year_q;
                    weekday_d = cap_weekday_q;
                end else begin
                    set_err_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (do_adv) begin
            weekday_d = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
            if (day_q < cur_len) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d       = 5'd1;
                new_month_d = 1'b1;
                if (month_q < 4'd12) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d    = 4'd1;
                    new_year_d = 1'b1;
                    year_d     = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update from the same pre-edge values.
            day_q         <= 5'(INIT_DAY);
            month_q       <= 4'(INIT_MONTH);
            year_q        <= 7'(INIT_YEAR);
            weekday_q     <= 3'(INIT_WEEKDAY);
            new_month_q   <= 1'b0;
            new_year_q    <= 1'b0;
            set_err_q     <= 1'b0;
            pending_q     <= 1'b0;
            // NOTE: the shadow registers are reset as well, so a reset in the
            // middle of validation cannot leave a stale request behind.
            cap_day_q     <= '0;
            cap_month_q   <= '0;
            cap_year_q    <= '0;
            cap_weekday_q <= '0;
        end else begin
            day_q         <= day_d;
            month_q       <= month_d;
            year_q        <= year_d;
            weekday_q     <= weekday_d;
            new_month_q   <= new_month_d;
            new_year_q    <= new_year_d;
            set_err_q     <= set_err_d;
            pending_q     <= pending_d;
            cap_day_q     <= cap_day_d;
            cap_month_q   <= cap_month_d;
            cap_year_q    <= cap_year_d;
            cap_weekday_q <= cap_weekday_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign weekday   = weekday_q;
    assign new_month = new_month_q;
    assign new_year  = new_year_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// -----------------------------------------------------------------------------
// tb_calendar_date_counter
//
// Self-checking bench for calendar_date_counter. A date model keeps the date
// as a day number counted from 1 Jan 2000 and converts it back to
// day/month/year with calendar arithmetic; it is compared against the DUT on
// every cycle out of reset. Directed cases with literal expectations pin the
// model, followed by randomized sets and day advances.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_calendar_date_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_day = 1'b0;
    logic       set_req = 1'b0;
    logic [4:0] set_day = '0;
    logic [3:0] set_month = '0;
    logic [6:0] set_year = '0;
    logic [2:0] set_weekday = '0;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [2:0] weekday;
    logic       new_month;
    logic       new_year;
    logic       busy;
    logic       set_err;

    always #5 clk = ~clk;

    calendar_date_counter dut (
        .clk         (clk),
        .reset       (rst_n),
        .new_day     (new_day),
        .set_req     (set_req),
        .set_day     (set_day),
        .set_month   (set_month),
        .set_year    (set_year),
        .set_weekday (set_weekday),
        .day         (day),
        .month       (month),
        .year        (year),
        .weekday     (weekday),
        .new_month   (new_month),
        .new_year    (new_year),
        .busy        (busy),
        .set_err     (set_err)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- calendar model
    function automatic bit is_leap(input int y);
`ifdef LEAP_YEAR_EN
        return (y % 4) == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mlen(input int m, input int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int r;
        r = t[m-1];
        if (m == 2 && is_leap(y)) r = 29;
        return r;
    endfunction

    function automatic int ylen(input int y);
        return is_leap(y) ? 366 : 365;
    endfunction

    function automatic int century_days();
        int s = 0;
        for (int y = 0; y < 100; y++) s += ylen(y);
        return s;
    endfunction

    function automatic int serial(input int d, input int m, input int y);
        int s = 0;
        for (int yy = 0; yy < y; yy++) s += ylen(yy);
        for (int mm = 1; mm < m; mm++) s += mlen(mm, y);
        return s + d - 1;
    endfunction

    task automatic to_dmy(input int n, output int d, output int m, output int y);
        y = 0;
        while (n >= ylen(y)) begin
            n -= ylen(y);
            y++;
        end
        m = 1;
        while (n >= mlen(m, y)) begin
            n -= mlen(m, y);
            m++;
        end
        d = n + 1;
    endtask

    function automatic bit date_ok(input int d, input int m, input int y, input int w);
        if (m < 1 || m > 12 || y > 99 || w > 6) return 1'b0;
        return (d >= 1) && (d <= mlen(m, y));
    endfunction

    // Model state: date as day number, weekday, and the set/pending bookkeeping.
    int m_n, m_wd;
    bit m_check, m_pend, m_nm, m_ny, m_err;
    int c_d, c_m, c_y, c_w;

    task automatic model_reset();
        m_n     = serial(1, 1, 0);
        m_wd    = 5;
        m_check = 0;
        m_pend  = 0;
        m_nm    = 0;
        m_ny    = 0;
        m_err   = 0;
    endtask

    task automatic model_advance();
        int d, m, y;
        m_n  = (m_n + 1) % century_days();
        m_wd = (m_wd + 1) % 7;
        to_dmy(m_n, d, m, y);
        m_nm = (d == 1);
        m_ny = (d == 1) && (m == 1);
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit adv;
            m_nm  = 0;
            m_ny  = 0;
            m_err = 0;
            if (m_check) begin
                m_check = 0;
                if (date_ok(c_d, c_m, c_y, c_w)) begin
                    m_n  = serial(c_d, c_m, c_y);
                    m_wd = c_w;
                end else begin
                    m_err = 1;
                end
                if (new_day) m_pend = 1;
            end else begin
                adv    = m_pend || (new_day && !set_req);
                m_pend = set_req && new_day;
                if (adv) model_advance();
                if (set_req) begin
                    m_check = 1;
                    c_d = int'(set_day);
                    c_m = int'(set_month);
                    c_y = int'(set_year);
                    c_w = int'(set_weekday);
                end
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            int d, m, y;
            to_dmy(m_n, d, m, y);
            check("cmp_day",       day,       d);
            check("cmp_month",     month,     m);
            check("cmp_year",      year,      y);
            check("cmp_weekday",   weekday,   m_wd);
            check("cmp_new_month", new_month, m_nm);
            check("cmp_new_year",  new_year,  m_ny);
            check("cmp_busy",      busy,      m_check);
            check("cmp_set_err",   set_err,   m_err);
        end
    end

    // ------------------------------------------------------- directed helpers
    task automatic expect_date(input string tag, input int d, input int m, input int y, input int w);
        check({tag, "_day"},     day,     d);
        check({tag, "_month"},   month,   m);
        check({tag, "_year"},    year,    y);
        check({tag, "_weekday"}, weekday, w);
    endtask

    // Returns just after the commit edge (set_err visible, pending not yet applied).
    task automatic do_set(input int d, input int m, input int y, input int w,
                          input bit nd_same, input bit nd_check);
        @(negedge clk);
        set_day     = 5'(d);
        set_month   = 4'(m);
        set_year    = 7'(y);
        set_weekday = 3'(w);
        set_req     = 1'b1;
        new_day     = nd_same;
        @(negedge clk);
        set_req = 1'b0;
        new_day = nd_check;
        check("busy_in_check", busy, 1);
        @(negedge clk);
        new_day = 1'b0;
    endtask

    task automatic pulse_day();
        @(negedge clk);
        new_day = 1'b1;
        @(negedge clk);
        new_day = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        model_reset();
        #12;
        expect_date("reset", 1, 1, 0, 5);
        check("reset_new_month", new_month, 0);
        check("reset_new_year",  new_year,  0);
        check("reset_busy",      busy,      0);
        check("reset_set_err",   set_err,   0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Month rollover, no year change.
        do_set(31, 1, 5, 2, 0, 0);
        expect_date("set_31_1_5", 31, 1, 5, 2);
        check("set_ok_err", set_err, 0);
        pulse_day();
        expect_date("adv_31_1_5", 1, 2, 5, 3);
        check("adv_31_1_5_nm", new_month, 1);
        check("adv_31_1_5_ny", new_year, 0);
        @(negedge clk);
        check("nm_one_cycle", new_month, 0);

        // February end, leap and non-leap.
        do_set(28, 2, 4, 0, 0, 0);
        pulse_day();
`ifdef LEAP_YEAR_EN
        expect_date("feb_leap", 29, 2, 4, 1);
        check("feb_leap_nm", new_month, 0);
`else
        expect_date("feb_leap", 1, 3, 4, 1);
        check("feb_leap_nm", new_month, 1);
`endif
        do_set(28, 2, 5, 0, 0, 0);
        pulse_day();
        expect_date("feb_plain", 1, 3, 5, 1);
        check("feb_plain_nm", new_month, 1);

        // 29 Feb in a leap year: valid only with the leap feature.
        do_set(29, 2, 8, 3, 0, 0);
`ifdef LEAP_YEAR_EN
        check("feb29_err", set_err, 0);
        expect_date("feb29", 29, 2, 8, 3);
`else
        check("feb29_err", set_err, 1);
        expect_date("feb29", 1, 3, 5, 1);
`endif

        // Century wrap.
        do_set(31, 12, 99, 6, 0, 0);
        pulse_day();
        expect_date("wrap", 1, 1, 0, 0);
        check("wrap_nm", new_month, 1);
        check("wrap_ny", new_year, 1);

        // Rejected sets leave the date alone.
        do_set(31, 4, 10, 3, 0, 0);
        check("bad_31_4_err", set_err, 1);
        expect_date("bad_31_4", 1, 1, 0, 0);
        @(negedge clk);
        check("err_one_cycle", set_err, 0);
        do_set(13, 13, 10, 3, 0, 0);
        check("bad_13_13_err", set_err, 1);
        expect_date("bad_13_13", 1, 1, 0, 0);

        // new_day coinciding with the request, then during validation.
        do_set(15, 6, 20, 4, 1, 0);
        expect_date("pend_same", 15, 6, 20, 4);
        @(negedge clk);
        expect_date("pend_same_adv", 16, 6, 20, 5);
        do_set(15, 6, 20, 4, 0, 1);
        expect_date("pend_check", 15, 6, 20, 4);
        @(negedge clk);
        expect_date("pend_check_adv", 16, 6, 20, 5);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_date("async_rst", 1, 1, 0, 5);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during validation discards the captured request.
        @(negedge clk);
        set_day = 5'd20; set_month = 4'd7; set_year = 7'd30; set_weekday = 3'd1;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        check("rst_check_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_check_busy_clr", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expect_date("rst_check_discard", 1, 1, 0, 5);

        // Randomized phase.
        repeat (4000) begin
            bit sr, nd;
            @(negedge clk);
            sr = 0;
            nd = 0;
            if (m_check) begin
                nd = !m_pend && ($urandom % 3 == 0);
                sr = ($urandom % 4 == 0);
            end else if (!m_pend) begin
                sr = ($urandom % 8 == 0);
                nd = ($urandom % 3 == 0);
            end
            if ($urandom % 5 == 0) begin
                set_day     = 5'($urandom);
                set_month   = 4'($urandom);
                set_year    = 7'($urandom);
                set_weekday = 3'($urandom);
            end else begin
                set_month   = 4'($urandom_range(1, 12));
                set_year    = ($urandom % 4 == 0) ? 7'd99 : 7'($urandom_range(0, 99));
                set_day     = 5'($urandom_range(26, 31));
                set_weekday = 3'($urandom_range(0, 6));
            end
            set_req = sr;
            new_day = nd;
        end
        @(negedge clk);
        set_req = 1'b0;
        new_day = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
